// File: rtl/irq_pkg.sv
// Shared constants and helpers for the interrupt controller slice.
package irq_pkg;

    localparam int unsigned NSRC = 8;
    localparam logic [7:0] VECTOR_NONE = 8'h80;

    typedef enum logic [2:0] {
        IRQ_STATUS  = 3'd0,
        IRQ_PENDING = 3'd1,
        IRQ_ENABLE  = 3'd2,
        IRQ_MODE    = 3'd3,
        IRQ_VECTOR  = 3'd4,
        IRQ_NMICTL  = 3'd5,
        IRQ_SWSET   = 3'd6,
        IRQ_RSVD    = 3'd7
    } irq_reg_e;

    // Index of the lowest set bit, or VECTOR_NONE when nothing is set.
    function automatic logic [7:0] lowest_set(input logic [NSRC-1:0] v);
        logic [7:0] r;
        r = VECTOR_NONE;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (v[i] && r == VECTOR_NONE) r = 8'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/irq_ctl_if.sv
// CPU bus seen by the interrupt controller: address/write strobe in, registered read data out.
interface irq_ctl_if;
    logic [15:0] AD;
    logic [7:0]  DO;
    logic        WE;
    logic [7:0]  rd_data;
    logic        rd_hit;

    modport master (output AD, output DO, output WE, input rd_data, input rd_hit);
    modport slave  (input AD, input DO, input WE, output rd_data, output rd_hit);
endinterface

// File: rtl/irq_sync.sv
// Multi-flop synchroniser for asynchronous inputs with a configurable reset value.
module irq_sync #(
    parameter int unsigned WIDTH   = 1,
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] ff [STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < STAGES; i++) ff[i] <= {WIDTH{RST_VAL}};
        end else begin
            ff[0] <= d;
            for (int unsigned i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/irq_ctl.sv
// Memory-mapped interrupt controller: synchronises 8 sources plus NMI, latches/masks them,
// and drives registered IRQ/NMI into the cpu core.
module irq_ctl
    import irq_pkg::*;
#(
    parameter logic [15:0] BASE        = 16'hFE00,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            RST,
    irq_ctl_if.slave        bus,
    input  logic [NSRC-1:0] src,
    input  logic            nmi_n,
    output logic            IRQ,
    output logic            NMI
);

    logic [NSRC-1:0] s, s_d;
    logic            ns, ns_d;
    logic [NSRC-1:0] pend_q, enable_q, mode_q;
    logic            nmi_en_q, nmi_pend_q;

    logic            hit, wr, rd;
    irq_reg_e        off;
    logic [NSRC-1:0] eff_pend, status, edge_set, sw_set, pend_clr;
    logic            nmi_clr, nmi_fall;
    logic [7:0]      rd_mux;

    irq_sync #(.WIDTH(NSRC), .STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_src_sync (
        .clk (clk),
        .rst (RST),
        .d   (src),
        .q   (s)
    );

    irq_sync #(.WIDTH(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_nmi_sync (
        .clk (clk),
        .rst (RST),
        .d   (nmi_n),
        .q   (ns)
    );

    always_comb begin
        hit      = (bus.AD[15:3] == BASE[15:3]);
        off      = irq_reg_e'(bus.AD[2:0]);
        wr       = hit & bus.WE;
        rd       = hit & ~bus.WE;
        sw_set   = (wr && off == IRQ_SWSET)   ? bus.DO : '0;
        pend_clr = (wr && off == IRQ_PENDING) ? bus.DO : '0;
        nmi_clr  = wr && off == IRQ_NMICTL && bus.DO[1];
        edge_set = s & ~s_d & mode_q;
        nmi_fall = ns_d & ~ns;
        // Level sources bypass pend_q so a W1C cannot hide an input that is still high.
        eff_pend = pend_q | (~mode_q & s);
        status   = eff_pend & enable_q;
        rd_mux   = '0;
        case (off)
            IRQ_STATUS:  rd_mux = status;
            IRQ_PENDING: rd_mux = eff_pend;
            IRQ_ENABLE:  rd_mux = enable_q;
            IRQ_MODE:    rd_mux = mode_q;
            IRQ_VECTOR:  rd_mux = lowest_set(status);
            IRQ_NMICTL:  rd_mux = {6'b0, nmi_pend_q, nmi_en_q};
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            s_d         <= '0;
            ns_d        <= 1'b1;
            pend_q      <= '0;
            enable_q    <= '0;
            mode_q      <= '0;
            nmi_en_q    <= 1'b0;
            nmi_pend_q  <= 1'b0;
            IRQ         <= 1'b0;
            NMI         <= 1'b0;
            bus.rd_data <= '0;
            bus.rd_hit  <= 1'b0;
        end else begin
            s_d        <= s;
            ns_d       <= ns;
            // Clear applied before set so a coincident edge is never lost.
            pend_q     <= (pend_q & ~pend_clr) | edge_set | sw_set;
            nmi_pend_q <= (nmi_pend_q & ~nmi_clr) | nmi_fall;
            if (wr) begin
                case (off)
                    IRQ_ENABLE: enable_q <= bus.DO;
                    IRQ_MODE:   mode_q   <= bus.DO;
                    IRQ_NMICTL: nmi_en_q <= bus.DO[0];
                    default:    ;
                endcase
            end
            IRQ        <= |status;
            NMI        <= nmi_pend_q & nmi_en_q;
            bus.rd_hit <= rd;
            if (rd) bus.rd_data <= rd_mux;
        end
    end

endmodule
